// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D main-memory arbiter.
// Block geometry and memory latency defaults live here so the bench and RTL agree.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LAT     = 4;
  localparam int unsigned IDX_W       = $clog2(BLOCK_WORDS);
  localparam int unsigned BLOCK_MASK  = 2 * BLOCK_WORDS - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that did not win last time.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic  i_i_req,
  input  logic  i_d_req,
  input  side_t i_last,
  output logic  o_valid_c,
  output side_t o_pick_c
);

  always_comb begin
    o_valid_c = i_i_req | i_d_req;
    o_pick_c  = SIDE_I;
    if (i_i_req && i_d_req) begin
      o_pick_c = (i_last == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (i_d_req) begin
      o_pick_c = SIDE_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache and D-cache miss handlers:
// 8-word block fills for either side and single-word D write-through stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int unsigned CNT_W = IDX_W + 1;

  arb_state_t        r_state;
  arb_state_t        w_next;
  side_t             r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [IDX_W-1:0]  r_ret_cnt;

  logic              w_pick_valid;
  side_t             w_pick;
  logic              w_fill;
  logic              w_issuing;
  logic              w_ret;
  logic              w_last_ret;

  mem_arb_rr u_rr (
    .i_i_req   (i_req),
    .i_d_req   (d_req),
    .i_last    (r_last),
    .o_valid_c (w_pick_valid),
    .o_pick_c  (w_pick)
  );

  assign w_fill     = (r_state == ST_I_FILL) || (r_state == ST_D_FILL);
  assign w_issuing  = w_fill && (r_issue_cnt < CNT_W'(BLOCK_WORDS));
  assign w_ret      = w_fill && mem_rvalid;
  assign w_last_ret = w_ret && (r_ret_cnt == IDX_W'(BLOCK_WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: requests are only looked at in IDLE, so every transaction is
  // followed by at least one IDLE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          if (w_pick == SIDE_I) begin
            w_next = ST_I_FILL;
          end else if (d_we) begin
            w_next = ST_D_WRITE;
          end else begin
            w_next = ST_D_FILL;
          end
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (w_last_ret) begin
          w_next = ST_IDLE;
        end
      end
      ST_D_WRITE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Grant-time latches and issue/return counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= SIDE_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      if (w_pick_valid) begin
        r_last  <= w_pick;
        r_wdata <= d_wdata;
        if (w_pick == SIDE_I) begin
          r_addr <= i_addr & ~ADDR_W'(BLOCK_MASK);
        end else if (d_we) begin
          r_addr <= d_addr & ~ADDR_W'(1);
        end else begin
          r_addr <= d_addr & ~ADDR_W'(BLOCK_MASK);
        end
      end
    end else begin
      if (w_issuing) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_ret) begin
        r_ret_cnt <= r_ret_cnt + IDX_W'(1);
      end
    end
  end

  // Output steering
  always_comb begin
    i_grant   = 1'b0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_grant   = 1'b0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_I_FILL: begin
        i_grant  = 1'b1;
        i_rvalid = mem_rvalid;
        i_done   = w_last_ret;
      end
      ST_D_FILL: begin
        d_grant  = 1'b1;
        d_rvalid = mem_rvalid;
        d_done   = w_last_ret;
      end
      ST_D_WRITE: begin
        d_grant   = 1'b1;
        d_done    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      default: ;
    endcase
    if (w_issuing) begin
      mem_en   = 1'b1;
      mem_addr = r_addr + ADDR_W'({r_issue_cnt[IDX_W-1:0], 1'b0});
    end
  end

  assign rsp_data = mem_rdata;
  assign rsp_idx  = r_ret_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model, arbitration table, directed
// corner sequences and randomized rounds against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_grant, i_rvalid, i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_grant, d_rvalid, d_done;
  logic [DW-1:0] rsp_data;
  logic [IDX_W-1:0] rsp_idx;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_done(d_done),
    .rsp_data(rsp_data), .rsp_idx(rsp_idx),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // Pipelined memory: not reset, so reads in flight still return after a DUT reset.
  logic [DW-1:0]      mem_ovr [MW] = '{default: '0};
  logic               mem_set [MW] = '{default: 1'b0};
  logic [MEM_LAT-1:0] pv = '0;
  logic [DW-1:0]      pd [MEM_LAT] = '{default: '0};
  logic               stray = 1'b0;

  function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
    int unsigned w;
    w = 32'(a[10:1]);
    return mem_set[w] ? mem_ovr[w] : DW'(32'hA000 + w);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem_ovr[mem_addr[10:1]] <= mem_wdata;
      mem_set[mem_addr[10:1]] <= 1'b1;
    end
    pv    <= {pv[MEM_LAT-2:0], mem_en && !mem_wr};
    pd[0] <= bus_rd(mem_addr);
    for (int k = 1; k < MEM_LAT; k++) pd[k] <= pd[k-1];
  end

  assign mem_rvalid = pv[MEM_LAT-1] | stray;
  assign mem_rdata  = pd[MEM_LAT-1];

  // Reference model: word contents as the caches expect them, plus who won last.
  logic [DW-1:0] ref_ovr [int];
  logic          model_last_d = 1'b0;
  logic [DW-1:0] last_fill [BLOCK_WORDS];

  function automatic logic [DW-1:0] ref_rd(input int unsigned w);
    if (ref_ovr.exists(int'(w))) return ref_ovr[int'(w)];
    return DW'(32'hA000 + w);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    check("grant_overlap", 32'(i_grant & d_grant), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_grant"}, 32'({i_grant, d_grant}), 32'd0);
    check({name, "_rvalid"}, 32'({i_rvalid, d_rvalid}), 32'd0);
    check({name, "_done"}, 32'({i_done, d_done}), 32'd0);
    check({name, "_mem"}, 32'({mem_en, mem_wr}), 32'd0);
  endtask

  // Wait for the next grant, check it against the expected side, follow the
  // transaction to done, then release the request (unless hold) and check the IDLE gap.
  task automatic do_txn(input logic exp_d, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit hold);
    int n, cyc, k;
    logic [AW-1:0] base;
    logic [31:0] issues [$];
    n = 0;
    do begin
      step();
      n++;
    end while (!(i_grant || d_grant) && n < 4);
    check("grant_seen", 32'(i_grant | d_grant), 32'd1);
    if (!(i_grant || d_grant)) return;
    check("grant_side", 32'(d_grant), 32'(exp_d));
    model_last_d = exp_d;
    if (exp_d && we) begin
      check("wr_en", 32'({mem_en, mem_wr}), 32'd3);
      check("wr_addr", 32'(mem_addr), 32'(addr & ~AW'(1)));
      check("wr_data", 32'(mem_wdata), 32'(wdata));
      check("wr_done", 32'(d_done), 32'd1);
      ref_ovr[int'(addr[10:1])] = wdata;
    end else begin
      base = addr & ~AW'(2 * BLOCK_WORDS - 1);
      cyc = 0;
      k = 0;
      forever begin
        if (mem_en) issues.push_back(mem_wr ? 32'hFFFF_FFFF : 32'(mem_addr));
        if (exp_d ? d_rvalid : i_rvalid) begin
          check("rsp_idx", 32'(rsp_idx), 32'(k % BLOCK_WORDS));
          check("rsp_data", 32'(rsp_data), 32'(ref_rd(32'(base[10:1]) + 32'(k))));
          last_fill[k % BLOCK_WORDS] = rsp_data;
          k++;
        end
        check("other_side_quiet", 32'(exp_d ? (i_rvalid | i_done) : (d_rvalid | d_done)), 32'd0);
        check("grant_held", 32'(exp_d ? d_grant : i_grant), 32'd1);
        if ((exp_d ? d_done : i_done) || cyc >= 20) break;
        // Owner's inputs are don't-care once granted
        if (exp_d) begin
          d_addr  = AW'($urandom_range(0, 16'h7FF));
          d_we    = 1'($urandom_range(0, 1));
          d_wdata = DW'($urandom);
        end else begin
          i_addr = AW'($urandom_range(0, 16'h7FF));
        end
        step();
        cyc++;
      end
      check("fill_cycles", 32'(cyc), 32'(BLOCK_WORDS + MEM_LAT - 1));
      check("fill_words", 32'(k), 32'(BLOCK_WORDS));
      check("issue_count", 32'(issues.size()), 32'(BLOCK_WORDS));
      foreach (issues[j]) check("issue_addr", issues[j], 32'(base) + 32'(2 * j));
    end
    if (!hold) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    step();
    check("idle_gap", 32'({i_grant, d_grant}), 32'd0);
  endtask

  typedef struct {
    bit ir;
    bit dr;
    bit dwe;
    bit first_d;
    int n_grants;
  } arb_vec_t;

  arb_vec_t tbl [9];

  initial begin
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    bit            ir, dr, dwe, first_d;

    // Grant order, derived from round-robin rule starting from last=I
    tbl[0] = '{1, 1, 0, 1, 2};
    tbl[1] = '{1, 1, 1, 1, 2};
    tbl[2] = '{1, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 1, 1, 1};
    tbl[4] = '{1, 1, 0, 0, 2};
    tbl[5] = '{0, 1, 0, 1, 1};
    tbl[6] = '{1, 1, 1, 0, 2};
    tbl[7] = '{1, 0, 0, 0, 1};
    tbl[8] = '{1, 1, 0, 1, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_quiet("reset");
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", 32'(mem_wdata), 32'd0);
    check("reset_idx", 32'(rsp_idx), 32'd0);
    rst_n = 1'b1;
    step();

    // I fill from a mid-block address
    i_addr = 16'h0046;
    i_req  = 1'b1;
    do_txn(1'b0, 1'b0, 16'h0046, '0, 1'b0);
    check("fill1_first", 32'(last_fill[0]), 32'h0000_A020);
    check("fill1_last", 32'(last_fill[BLOCK_WORDS-1]), 32'h0000_A027);

    // Arbitration table
    foreach (tbl[r]) begin
      ia = AW'($urandom_range(0, 16'h7FF));
      da = AW'($urandom_range(0, 16'h7FF));
      wd = DW'($urandom);
      i_req = tbl[r].ir; i_addr = ia;
      d_req = tbl[r].dr; d_we = tbl[r].dwe; d_addr = da; d_wdata = wd;
      do_txn(tbl[r].first_d, tbl[r].first_d & tbl[r].dwe, tbl[r].first_d ? da : ia, wd, 1'b0);
      if (tbl[r].n_grants == 2)
        do_txn(!tbl[r].first_d, !tbl[r].first_d & tbl[r].dwe, tbl[r].first_d ? ia : da, wd, 1'b0);
    end

    // Write-through then fill of the same block sees the new word
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0082; d_wdata = 16'hBEEF;
    do_txn(1'b1, 1'b1, 16'h0082, 16'hBEEF, 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
    do_txn(1'b1, 1'b0, 16'h0080, '0, 1'b0);
    check("wr_then_fill", 32'(last_fill[1]), 32'h0000_BEEF);

    // Stray memory return while idle
    stray = 1'b1;
    #1;
    check_quiet("stray");
    step();
    stray = 1'b0;
    check("stray_after_idx", 32'(rsp_idx), 32'd0);

    // Reset in the fifth cycle of an I fill
    i_addr = 16'h0120;
    i_req  = 1'b1;
    step();
    check("rst_fill_grant", 32'(i_grant), 32'd1);
    repeat (4) step();
    rst_n = 1'b0;
    i_req = 1'b0;
    model_last_d = 1'b0;
    #1;
    check_quiet("rst_mid");
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_idx", 32'(rsp_idx), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_quiet("late_ret");
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    do_txn(1'b1, 1'b0, 16'h0100, '0, 1'b0);

    // Requester holds req past done: re-granted only after the IDLE gap
    i_addr = 16'h0200;
    i_req  = 1'b1;
    do_txn(1'b0, 1'b0, 16'h0200, '0, 1'b1);
    do_txn(1'b0, 1'b0, i_addr, '0, 1'b0);

    // Randomized rounds against the model
    for (int r = 0; r < 25; r++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      dwe = 1'($urandom_range(0, 1));
      ia  = AW'($urandom_range(0, 16'h7FF));
      da  = AW'($urandom_range(0, 16'h7FF));
      wd  = DW'($urandom);
      first_d = (ir && dr) ? !model_last_d : dr;
      i_req = ir; i_addr = ia;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = wd;
      do_txn(first_d, first_d & dwe, first_d ? da : ia, wd, 1'b0);
      if (ir && dr) do_txn(!first_d, !first_d & dwe, first_d ? ia : da, wd, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        stray = 1'b1;
        #1;
        check_quiet("rand_stray");
        step();
        stray = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
